// File: rtl/regfile_pkg.sv
// Shared defaults and size helpers for the scoreboarded register file.
package regfile_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_NRD    = 2;

  function automatic int nregs(input int aw);
    return 1 << aw;
  endfunction

  localparam int DEF_NREGS = nregs(DEF_ADDR_W);
  // busy_cnt must hold NREGS itself, hence one bit wider than an address
  localparam int DEF_CNT_W = DEF_ADDR_W + 1;
endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the register file: read ports, writeback, alloc, flush.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD
);
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  alloc_valid;
  logic [ADDR_W-1:0]     alloc_addr;
  logic                  alloc_ready;
  logic                  flush;
  logic [ADDR_W:0]       busy_cnt;

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_valid, alloc_addr, flush,
    output rd_data, rd_busy, alloc_ready, busy_cnt
  );
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_valid, alloc_addr, flush,
    input  rd_data, rd_busy, alloc_ready, busy_cnt
  );
endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: storage mux, writeback bypass, r0 gating, hazard bit.
module regfile_read_port #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]                    i_addr,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]   i_mem,
  input  logic [(1<<ADDR_W)-1:0]               i_pend,
  input  logic                                 i_wr_en,
  input  logic [ADDR_W-1:0]                    i_wr_addr,
  input  logic [DATA_W-1:0]                    i_wr_data,
  output logic [DATA_W-1:0]                    o_data,
  output logic                                 o_busy
);
  logic w_hit, w_zero;

  assign w_hit  = i_wr_en && (i_wr_addr == i_addr);
  assign w_zero = (ZERO_REG != 0) && (i_addr == '0);

  always_comb begin
    o_data = i_mem[i_addr];
    if ((BYPASS != 0) && w_hit) o_data = i_wr_data;
    if (w_zero)                 o_data = '0;
  end

  // A writeback this cycle releases the hazard even without data bypass
  assign o_busy = i_pend[i_addr] & ~w_hit & ~w_zero;
endmodule

// File: rtl/regfile_sb.sv
// Register file with NRD read ports, write bypass and per-register pending scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave bus
);
  localparam int NREGS = nregs(ADDR_W);

  logic [NREGS-1:0][DATA_W-1:0] r_mem;
  logic [NREGS-1:0]             r_pend;
  logic [ADDR_W:0]              r_cnt;

  logic w_wr_ok, w_alloc_zero, w_wr_hit_alloc, w_alloc_ok, w_set, w_inc, w_dec;
  logic [NRD-1:0][DATA_W-1:0]   w_rd_data;

  assign w_wr_ok        = bus.wr_en & ~((ZERO_REG != 0) && (bus.wr_addr == '0));
  assign w_alloc_zero   = (ZERO_REG != 0) && (bus.alloc_addr == '0);
  assign w_wr_hit_alloc = bus.wr_en && (bus.wr_addr == bus.alloc_addr);
  assign w_alloc_ok     = bus.alloc_valid & ~bus.flush &
                          (~r_pend[bus.alloc_addr] | w_wr_hit_alloc);
  assign w_set          = w_alloc_ok & ~w_alloc_zero;
  // Count only real transitions so write+alloc on a pending reg nets to zero
  assign w_inc          = w_set & ~r_pend[bus.alloc_addr];
  assign w_dec          = w_wr_ok & r_pend[bus.wr_addr] & ~(w_set & w_wr_hit_alloc);

  assign bus.alloc_ready = w_alloc_ok;
  assign bus.busy_cnt    = r_cnt;
  assign bus.rd_data     = w_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem  <= '0;
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr_ok) r_mem[bus.wr_addr] <= bus.wr_data;
      if (bus.flush) begin
        r_pend <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_dec) r_pend[bus.wr_addr]    <= 1'b0;
        if (w_set) r_pend[bus.alloc_addr] <= 1'b1;
        r_cnt <= r_cnt + {{ADDR_W{1'b0}}, w_inc} - {{ADDR_W{1'b0}}, w_dec};
      end
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    regfile_read_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .i_addr    (bus.rd_addr[g*ADDR_W +: ADDR_W]),
      .i_mem     (r_mem),
      .i_pend    (r_pend),
      .i_wr_en   (bus.wr_en),
      .i_wr_addr (bus.wr_addr),
      .i_wr_data (bus.wr_data),
      .o_data    (w_rd_data[g]),
      .o_busy    (bus.rd_busy[g])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Vector/scoreboard bench: dut_a (no r0, bypass) and dut_b (hardwired r0, no bypass).
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if ifa ();
  regfile_sb_if ifb ();

  regfile_sb #(.ZERO_REG(0), .BYPASS(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  regfile_sb #(.ZERO_REG(1), .BYPASS(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  typedef struct {
    bit          b;
    logic [3:0]  rd0, rd1;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        av;
    logic [3:0]  aa;
    logic        fl;
    logic [15:0] e_d0, e_d1;
    logic [1:0]  e_busy;
    logic        e_rdy;
    logic [4:0]  e_cnt;
    string       name;
  } vec_t;

  vec_t        exp_q[$];
  vec_t        tbl[14];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] mdl[16];

  function automatic vec_t mk(bit b, logic [3:0] r0, logic [3:0] r1, logic we,
                              logic [3:0] wa, logic [15:0] wd, logic av, logic [3:0] aa,
                              logic fl, logic [15:0] d0, logic [15:0] d1, logic [1:0] bz,
                              logic rdy, logic [4:0] cnt, string nm);
    vec_t v;
    v.b = b; v.rd0 = r0; v.rd1 = r1; v.we = we; v.wa = wa; v.wd = wd;
    v.av = av; v.aa = aa; v.fl = fl; v.e_d0 = d0; v.e_d1 = d1;
    v.e_busy = bz; v.e_rdy = rdy; v.e_cnt = cnt; v.name = nm;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    if (!v.b) begin
      ifa.rd_addr = {v.rd1, v.rd0}; ifa.wr_en = v.we; ifa.wr_addr = v.wa;
      ifa.wr_data = v.wd; ifa.alloc_valid = v.av; ifa.alloc_addr = v.aa; ifa.flush = v.fl;
    end else begin
      ifb.rd_addr = {v.rd1, v.rd0}; ifb.wr_en = v.we; ifb.wr_addr = v.wa;
      ifb.wr_data = v.wd; ifb.alloc_valid = v.av; ifb.alloc_addr = v.aa; ifb.flush = v.fl;
    end
    exp_q.push_back(v);
  endtask

  task automatic check();
    vec_t        e;
    logic [31:0] d;
    logic [1:0]  bz;
    logic        rdy;
    logic [4:0]  cnt;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: got empty queue, want an expected entry");
    end else begin
      e   = exp_q.pop_front();
      d   = e.b ? ifb.rd_data : ifa.rd_data;
      bz  = e.b ? ifb.rd_busy : ifa.rd_busy;
      rdy = e.b ? ifb.alloc_ready : ifa.alloc_ready;
      cnt = e.b ? ifb.busy_cnt : ifa.busy_cnt;
      if (d !== {e.e_d1, e.e_d0} || bz !== e.e_busy || rdy !== e.e_rdy || cnt !== e.e_cnt) begin
        n_err++;
        $display("FAIL %s: got d0=%h d1=%h busy=%b rdy=%b cnt=%0d, want d0=%h d1=%h busy=%b rdy=%b cnt=%0d",
                 e.name, d[15:0], d[31:16], bz, rdy, cnt,
                 e.e_d0, e.e_d1, e.e_busy, e.e_rdy, e.e_cnt);
      end
    end
  endtask

  task automatic step(input vec_t v);
    @(posedge clk); #1;
    apply(v);
    @(negedge clk);
    check();
  endtask

  task automatic idle_all();
    ifa.rd_addr = '0; ifa.wr_en = 0; ifa.wr_addr = '0; ifa.wr_data = '0;
    ifa.alloc_valid = 0; ifa.alloc_addr = '0; ifa.flush = 0;
    ifb.rd_addr = '0; ifb.wr_en = 0; ifb.wr_addr = '0; ifb.wr_data = '0;
    ifb.alloc_valid = 0; ifb.alloc_addr = '0; ifb.flush = 0;
  endtask

  initial begin
    idle_all();
    // During reset everything reads zero and alloc_ready tracks alloc_valid
    for (int i = 0; i < 16; i++)
      step(mk(0, 4'(i), 4'(15 - i), 0, 0, 0, 1, 4'(i), 0, 0, 0, 2'b00, 1, 0, "reset"));
    @(posedge clk); #1;
    idle_all();
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0]  = mk(0, 5, 5, 1, 5, 16'hBEEF, 0, 0, 0, 16'hBEEF, 16'hBEEF, 2'b00, 0, 0, "wr_bypass");
    tbl[1]  = mk(0, 5, 0, 0, 0, 0,        0, 0, 0, 16'hBEEF, 16'h0000, 2'b00, 0, 0, "wr_stored");
    tbl[2]  = mk(0, 3, 5, 0, 0, 0,        1, 3, 0, 16'h0000, 16'hBEEF, 2'b00, 1, 0, "alloc3");
    tbl[3]  = mk(0, 3, 5, 0, 0, 0,        1, 3, 0, 16'h0000, 16'hBEEF, 2'b01, 0, 1, "alloc3_again");
    tbl[4]  = mk(0, 3, 3, 1, 3, 16'h1234, 0, 0, 0, 16'h1234, 16'h1234, 2'b00, 0, 1, "release3");
    tbl[5]  = mk(0, 3, 5, 0, 0, 0,        0, 0, 0, 16'h1234, 16'hBEEF, 2'b00, 0, 0, "released");
    tbl[6]  = mk(0, 3, 5, 0, 0, 0,        1, 3, 0, 16'h1234, 16'hBEEF, 2'b00, 1, 0, "realloc3");
    tbl[7]  = mk(0, 3, 5, 1, 3, 16'h4321, 1, 3, 0, 16'h4321, 16'hBEEF, 2'b00, 1, 1, "wr_alloc_same");
    tbl[8]  = mk(0, 3, 3, 0, 0, 0,        0, 0, 0, 16'h4321, 16'h4321, 2'b11, 0, 1, "alloc_wins");
    tbl[9]  = mk(0, 3, 9, 1, 3, 16'h0F0F, 1, 9, 0, 16'h0F0F, 16'h0000, 2'b00, 1, 1, "wr3_alloc9");
    tbl[10] = mk(0, 3, 9, 0, 0, 0,        0, 0, 0, 16'h0F0F, 16'h0000, 2'b10, 0, 1, "net_zero");
    tbl[11] = mk(0, 7, 9, 1, 7, 16'h7777, 0, 0, 0, 16'h7777, 16'h0000, 2'b10, 0, 1, "wr_not_pend");
    tbl[12] = mk(0, 7, 9, 1, 9, 16'h9999, 0, 0, 0, 16'h7777, 16'h9999, 2'b00, 0, 1, "release9");
    tbl[13] = mk(0, 9, 7, 0, 0, 0,        0, 0, 0, 16'h9999, 16'h7777, 2'b00, 0, 0, "cnt_zero");
    for (int i = 0; i < 14; i++) step(tbl[i]);

    for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
    mdl[3] = 16'h0F0F; mdl[5] = 16'hBEEF; mdl[7] = 16'h7777; mdl[9] = 16'h9999;

    // Fill every register so busy_cnt reaches NREGS, then flush over a write+alloc
    for (int i = 0; i < 16; i++)
      step(mk(0, 4'(i), 4'(i), 0, 0, 0, 1, 4'(i), 0, mdl[i], mdl[i], 2'b00, 1, 5'(i), "alloc_all"));
    step(mk(0, 7, 0, 1, 7, 16'h00AA, 1, 7, 1, 16'h00AA, mdl[0], 2'b10, 0, 5'd16, "flush_cycle"));
    mdl[7] = 16'h00AA;
    for (int i = 0; i < 8; i++)
      step(mk(0, 4'(i), 4'(i + 8), 0, 0, 0, 0, 0, 0, mdl[i], mdl[i + 8], 2'b00, 0, 0, "post_flush"));
    idle_all();

    step(mk(1, 5, 0, 1, 5, 16'hBEEF, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, "nobypass"));
    step(mk(1, 5, 0, 0, 0, 0,        0, 0, 0, 16'hBEEF, 16'h0000, 2'b00, 0, 0, "nobypass_next"));
    step(mk(1, 0, 5, 1, 0, 16'hFFFF, 1, 0, 0, 16'h0000, 16'hBEEF, 2'b00, 1, 0, "r0_wr_alloc"));
    step(mk(1, 0, 5, 0, 0, 0,        0, 0, 0, 16'h0000, 16'hBEEF, 2'b00, 0, 0, "r0_after"));
    step(mk(1, 2, 2, 0, 0, 0,        1, 2, 0, 16'h0000, 16'h0000, 2'b00, 1, 0, "b_alloc2"));
    step(mk(1, 2, 5, 0, 0, 0,        0, 0, 0, 16'h0000, 16'hBEEF, 2'b01, 0, 1, "b_pending2"));

    // Async reset mid-cycle: state clears before the next edge
    @(posedge clk); #1;
    apply(mk(1, 5, 2, 1, 5, 16'h5555, 1, 6, 0, 16'h0000, 16'h0000, 2'b00, 1, 0, "rst_mid"));
    #2 rst_n = 1'b0;
    #1 check();
    @(posedge clk); #1;
    apply(mk(1, 5, 6, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, "rst_hold"));
    @(negedge clk);
    check();
    rst_n = 1'b1;
    step(mk(1, 5, 6, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, "post_rst"));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
